// File: rtl/fma_quire_seq.sv
// Saturating fixed-point accumulation sequencer for the FMADD path.
// Chains are framed by the first accepted FMADD beat and last_i (or a non-FMADD beat).
package ppu_pkg;
    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        MUL   = 3'd2,
        DIV   = 3'd3,
        FMADD = 3'd4,
        SQRT  = 3'd5
    } operation_e;
endpackage

// Handshakes: an input beat transfers on a rising edge with in_valid_i && in_ready_o;
// a result transfers on a rising edge with out_valid_o && out_ready_i.
module fma_quire_seq
    import ppu_pkg::*;
#(
    parameter int FX_B  = 64,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  operation_e       op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic             last_i,
    input  logic [FX_B-1:0]  init_i,
    input  logic [FX_B-1:0]  prod_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [FX_B-1:0]  acc_o,
    output logic [CNT_W-1:0] count_o,
    output logic             ovf_o,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [FX_B-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;

    logic             accept;
    logic             is_fma;
    logic [FX_B-1:0]  addend;
    logic [FX_B:0]    wide;
    logic             sat;
    logic [FX_B-1:0]  sum_sat;

    assign in_ready_o  = rst_i && (state_q != DONE);
    assign out_valid_o = (state_q == DONE);
    assign acc_o       = acc_q;
    assign count_o     = cnt_q;
    assign ovf_o       = ovf_q;
    assign dbg_state   = state_q;

    assign accept = in_valid_i && in_ready_o;
    assign is_fma = (op_i == FMADD);

    // First beat of a chain adds the fresh addend; later beats add to the running sum.
    assign addend = (state_q == IDLE) ? init_i : acc_q;
    assign wide   = {addend[FX_B-1], addend} + {prod_i[FX_B-1], prod_i};
    assign sat    = wide[FX_B] ^ wide[FX_B-1];

    always_comb begin
        sum_sat = wide[FX_B-1:0];
        if (sat) begin
            sum_sat = wide[FX_B] ? {1'b1, {(FX_B-1){1'b0}}} : {1'b0, {(FX_B-1){1'b1}}};
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (accept && is_fma) begin
                    acc_d   = sum_sat;
                    cnt_d   = CNT_W'(1);
                    ovf_d   = sat;
                    state_d = last_i ? DONE : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    if (is_fma) begin
                        acc_d = sum_sat;
                        cnt_d = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
                        ovf_d = ovf_q | sat;
                        if (last_i) state_d = DONE;
                    end else begin
                        // A foreign op closes the chain without contributing.
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_fma_quire_seq.sv
// Directed bench for fma_quire_seq at FX_B=16, CNT_W=4: a table of single-term
// chains plus hand-written multi-cycle sequences.
module tb_fma_quire_seq;
    import ppu_pkg::*;

    localparam int FX_B  = 16;
    localparam int CNT_W = 4;

    logic             clk_i = 1'b0;
    logic             rst_i;
    operation_e       op_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic             last_i;
    logic [FX_B-1:0]  init_i;
    logic [FX_B-1:0]  prod_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [FX_B-1:0]  acc_o;
    logic [CNT_W-1:0] count_o;
    logic             ovf_o;
    logic [1:0]       dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int last_waits;

    fma_quire_seq #(.FX_B(FX_B), .CNT_W(CNT_W)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .op_i       (op_i),
        .in_valid_i (in_valid_i),
        .in_ready_o (in_ready_o),
        .last_i     (last_i),
        .init_i     (init_i),
        .prod_i     (prod_i),
        .out_valid_o(out_valid_o),
        .out_ready_i(out_ready_i),
        .acc_o      (acc_o),
        .count_o    (count_o),
        .ovf_o      (ovf_o),
        .dbg_state  (dbg_state)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [15:0] init;
        logic [15:0] prod;
        logic [15:0] exp_acc;
        logic        exp_ovf;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Presents one beat from a negedge and returns just after the edge that accepts it.
    task automatic send_beat(input operation_e op, input logic [15:0] init,
                             input logic [15:0] prod, input logic last);
        @(negedge clk_i);
        op_i       = op;
        init_i     = init;
        prod_i     = prod;
        last_i     = last;
        in_valid_i = 1'b1;
        last_waits = 0;
        while (!in_ready_o && last_waits < 20) begin
            @(negedge clk_i);
            last_waits++;
        end
        if (!in_ready_o) begin
            n_checks++;
            n_fail++;
            $display("FAIL send_timeout: in_ready_o stayed 0 for %0d cycles", last_waits);
        end
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
    endtask

    // Consumes the result at the next edge and checks the handoff.
    task automatic finish_chain();
        @(negedge clk_i);
        out_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        out_ready_i = 1'b0;
        check("handoff_out_valid", 64'(out_valid_o), 64'd0);
        check("handoff_in_ready", 64'(in_ready_o), 64'd1);
    endtask

    initial begin
        vecs[0] = '{16'h0100, 16'h0040, 16'h0140, 1'b0};
        vecs[1] = '{16'h7F00, 16'h0200, 16'h7FFF, 1'b1};
        vecs[2] = '{16'h8000, 16'hFFFF, 16'h8000, 1'b1};
        vecs[3] = '{16'h8000, 16'h0000, 16'h8000, 1'b0};
        vecs[4] = '{16'hFFFF, 16'h0001, 16'h0000, 1'b0};
        vecs[5] = '{16'h7FFF, 16'h0001, 16'h7FFF, 1'b1};
        vecs[6] = '{16'h4000, 16'h4000, 16'h7FFF, 1'b1};
        vecs[7] = '{16'hC000, 16'hC000, 16'h8000, 1'b0};

        // Reset priority: a valid last beat is held throughout reset.
        rst_i       = 1'b0;
        op_i        = FMADD;
        in_valid_i  = 1'b1;
        last_i      = 1'b1;
        init_i      = 16'h0005;
        prod_i      = 16'h0003;
        out_ready_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk_i);
            #1;
            check("rst_in_ready", 64'(in_ready_o), 64'd0);
            check("rst_out_valid", 64'(out_valid_o), 64'd0);
            check("rst_acc", 64'(acc_o), 64'd0);
        end
        check("rst_count", 64'(count_o), 64'd0);
        check("rst_ovf", 64'(ovf_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        #1;
        check("post_rst_in_ready", 64'(in_ready_o), 64'd1);
        check("post_rst_out_valid", 64'(out_valid_o), 64'd0);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        check("first_accept_valid", 64'(out_valid_o), 64'd1);
        check("first_accept_acc", 64'(acc_o), 64'h0008);
        check("first_accept_count", 64'(count_o), 64'd1);
        finish_chain();

        // Single-term chains through the saturating adder.
        for (int i = 0; i < 8; i++) begin
            send_beat(FMADD, vecs[i].init, vecs[i].prod, 1'b1);
            check($sformatf("vec%0d_valid", i), 64'(out_valid_o), 64'd1);
            check($sformatf("vec%0d_acc", i), 64'(acc_o), 64'(vecs[i].exp_acc));
            check($sformatf("vec%0d_count", i), 64'(count_o), 64'd1);
            check($sformatf("vec%0d_ovf", i), 64'(ovf_o), 64'(vecs[i].exp_ovf));
            finish_chain();
        end

        // Four-term chain, back-to-back beats.
        send_beat(FMADD, 16'h0010, 16'h0001, 1'b0);
        check("chain4_wait0", 64'(last_waits), 64'd0);
        send_beat(FMADD, 16'hAAAA, 16'h0002, 1'b0);
        send_beat(FMADD, 16'hAAAA, 16'hFFFF, 1'b0);
        check("chain4_valid_early", 64'(out_valid_o), 64'd0);
        send_beat(FMADD, 16'hAAAA, 16'h0003, 1'b1);
        check("chain4_wait_last", 64'(last_waits), 64'd0);
        check("chain4_valid", 64'(out_valid_o), 64'd1);
        check("chain4_acc", 64'(acc_o), 64'h0015);
        check("chain4_count", 64'(count_o), 64'd4);
        finish_chain();

        // Saturation is sticky within the chain, then cleared by the next chain.
        send_beat(FMADD, 16'h7F00, 16'h0200, 1'b0);
        send_beat(FMADD, 16'h0000, 16'hFF00, 1'b1);
        check("satchain_acc", 64'(acc_o), 64'h7EFF);
        check("satchain_ovf", 64'(ovf_o), 64'd1);
        check("satchain_count", 64'(count_o), 64'd2);
        finish_chain();
        check("retain_acc", 64'(acc_o), 64'h7EFF);
        check("retain_ovf", 64'(ovf_o), 64'd1);
        send_beat(FMADD, 16'h0001, 16'h0001, 1'b1);
        check("clear_acc", 64'(acc_o), 64'h0002);
        check("clear_ovf", 64'(ovf_o), 64'd0);
        finish_chain();

        // Term counter saturates at 0xF.
        send_beat(FMADD, 16'h0000, 16'h0001, 1'b0);
        for (int i = 1; i < 16; i++) send_beat(FMADD, 16'h0000, 16'h0001, 1'b0);
        send_beat(FMADD, 16'h0000, 16'h0001, 1'b1);
        check("cnt_sat_count", 64'(count_o), 64'hF);
        check("cnt_sat_acc", 64'(acc_o), 64'h0011);
        check("cnt_sat_ovf", 64'(ovf_o), 64'd0);
        finish_chain();

        // Backpressure in DONE.
        send_beat(FMADD, 16'h0123, 16'h0001, 1'b1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk_i);
            #1;
            check("bp_out_valid", 64'(out_valid_o), 64'd1);
            check("bp_in_ready", 64'(in_ready_o), 64'd0);
            check("bp_acc", 64'(acc_o), 64'h0124);
        end
        finish_chain();
        send_beat(FMADD, 16'h0002, 16'h0003, 1'b1);
        check("bp_next_wait0", 64'(last_waits), 64'd0);
        check("bp_next_valid", 64'(out_valid_o), 64'd1);
        check("bp_next_acc", 64'(acc_o), 64'h0005);
        finish_chain();

        // Foreign op terminates a chain without being added.
        send_beat(FMADD, 16'h0020, 16'h0001, 1'b0);
        send_beat(FMADD, 16'h0000, 16'h0002, 1'b0);
        send_beat(MUL, 16'h0000, 16'h0100, 1'b0);
        check("term_valid", 64'(out_valid_o), 64'd1);
        check("term_count", 64'(count_o), 64'd2);
        check("term_acc", 64'(acc_o), 64'h0023);
        finish_chain();

        // Non-FMADD in IDLE is consumed with no effect.
        send_beat(ADD, 16'h1111, 16'h2222, 1'b1);
        check("idle_foreign_valid", 64'(out_valid_o), 64'd0);
        check("idle_foreign_acc", 64'(acc_o), 64'h0023);
        check("idle_foreign_count", 64'(count_o), 64'd2);

        // Mid-chain reset.
        send_beat(FMADD, 16'h0100, 16'h0001, 1'b0);
        send_beat(FMADD, 16'h0000, 16'h0001, 1'b0);
        check("midrst_pre_count", 64'(count_o), 64'd2);
        @(negedge clk_i);
        rst_i      = 1'b0;
        op_i       = FMADD;
        prod_i     = 16'h0007;
        last_i     = 1'b1;
        in_valid_i = 1'b1;
        #1;
        check("midrst_in_ready", 64'(in_ready_o), 64'd0);
        @(posedge clk_i);
        #1;
        in_valid_i = 1'b0;
        check("midrst_acc", 64'(acc_o), 64'd0);
        check("midrst_count", 64'(count_o), 64'd0);
        check("midrst_ovf", 64'(ovf_o), 64'd0);
        check("midrst_out_valid", 64'(out_valid_o), 64'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        send_beat(FMADD, 16'h0005, 16'h0005, 1'b1);
        check("restart_acc", 64'(acc_o), 64'h000A);
        check("restart_count", 64'(count_o), 64'd1);
        finish_chain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
